dsp_frame_engine: RTL and testbench
===================================

DSP_FRAME_ENGINE -- requirements
Module: dsp_frame_engine

Interface
REQ-001 SHALL have parameter W, default 16: sample and result width in bits.
REQ-002 SHALL have parameter DEPTH, default 64: frame buffer depth in samples (power of 2, at least 2).
REQ-003 SHALL have parameter ACCW, default 2*W+log2(DEPTH): internal accumulator width.
REQ-004 SHALL have port c, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port din, input, W bits: signed two's-complement sample.
REQ-007 SHALL have port regE, input, 1 bit: sample write strobe.
REQ-008 SHALL have port ext, input, 1 bit: start-processing strobe.
REQ-009 SHALL have port mode, input, 2 bits: operation select, sampled with ext.
REQ-010 SHALL have port dout, output, W bits: primary result.
REQ-011 SHALL have port dout1, output, W bits: secondary result.
REQ-012 SHALL have port busy, output, 1 bit: high while state is RUN.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse marking valid dout/dout1.
REQ-014 SHALL have port full, output, 1 bit: high when the frame count equals DEPTH.

Function
REQ-015 SHALL implement the states IDLE, RUN and DONE.
REQ-016 In IDLE, regE=1 with count<DEPTH SHALL write din to buf[count] and increment count.
REQ-017 In IDLE, regE=1 with count=DEPTH SHALL be ignored, and count and buffer SHALL be unchanged.
REQ-018 In IDLE, ext=1 with count>0 SHALL latch mode and N=count (including any same-cycle regE write), then go to RUN.
REQ-019 In IDLE, ext=1 with count=0 SHALL be ignored, with no done pulse.
REQ-020 RUN SHALL consume one sample per cycle, in order buf[0] to buf[N-1], over N cycles.
REQ-021 RUN SHALL then go to DONE for exactly one cycle, asserting done, then go to IDLE.
REQ-022 On the RUN-to-DONE transition, count SHALL clear to 0.
REQ-023 Latency SHALL be done asserted on the N+1th rising edge after the edge that sampled ext.
REQ-024 In RUN and DONE, regE and ext SHALL be ignored.
REQ-025 mode 00 SUM: dout SHALL be the signed sum saturated to [-2^(W-1), 2^(W-1)-1], and dout1 SHALL be N.
REQ-026 mode 01 MAXMIN: dout SHALL be the signed maximum and dout1 the signed minimum.
REQ-027 mode 10 ENERGY: the sum of squares SHALL accumulate in ACCW bits.
REQ-028 In ENERGY, dout SHALL be that sum saturated unsigned to 2^W-1, and dout1 SHALL be 1 if saturated, else 0.
REQ-029 mode 11 SHALL behave as SUM.
REQ-030 The accumulator SHALL never wrap for N<=DEPTH.
REQ-031 dout/dout1 SHALL update only at DONE and hold their value until the next DONE or reset.

Reset
REQ-032 While rst_n=0 (asynchronously), the block SHALL set state=IDLE, count=0, the accumulator and max/min registers to 0, and dout=0, dout1=0, busy=0, done=0, full=0.
REQ-033 Reset during RUN SHALL abort the frame with no done pulse.
REQ-034 Buffer contents need not be cleared on reset; they SHALL be unobservable because count=0.

Structure
REQ-035 Package dsp_pkg SHALL hold the mode encodings (MODE_SUM, MODE_MAXMIN, MODE_ENERGY) and the state enumeration.
REQ-036 The buffer SHALL be sub-module dsp_sample_buf, with one synchronous write port and one read port with a registered address.
REQ-037 The control logic and datapath SHALL remain in dsp_frame_engine.

Verification
REQ-038 Write 0..63 with regE, then ext with mode=00 -> done 65 cycles later, dout=2016, dout1=64, full high before ext.
REQ-039 Write -5, 7, 3, then ext with mode=01 -> dout=0x0007, dout1=0xFFFB, busy high for exactly 3 cycles.
REQ-040 Write 64 samples of 0x7FFF, then ext with mode=10 -> dout=0xFFFF, dout1=1.
REQ-041 Make 65 writes of 1 -> full after the 64th, the 65th is ignored, and SUM gives dout=64.
REQ-042 Drop rst_n in the 2nd RUN cycle -> all outputs 0 immediately and no done pulse.
REQ-043 ext then SUM on a new frame of {2} -> dout=2, dout1=1.
REQ-044 ext with count=0 -> no done and no busy.
REQ-045 regE and ext in the same cycle -> the written sample is included in the frame.

Source files
------------

// File: rtl/dsp_pkg.sv
// Shared encodings for the frame engine: operation modes and FSM states.
package dsp_pkg;

    localparam logic [1:0] MODE_SUM    = 2'b00;
    localparam logic [1:0] MODE_MAXMIN = 2'b01;
    localparam logic [1:0] MODE_ENERGY = 2'b10;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'b00;
    localparam state_t ST_RUN  = 2'b01;
    localparam state_t ST_DONE = 2'b10;

endpackage

// File: rtl/dsp_sample_buf.sv
// Frame sample store: one synchronous write port, one read port
// whose address is registered (data follows the address one cycle later).
module dsp_sample_buf #(
    parameter int W     = 16,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          c,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0]  mem [0:DEPTH-1];
    logic [AW-1:0] raddr_q;

    always_ff @(posedge c) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            raddr_q <= '0;
        end else begin
            raddr_q <= raddr;
        end
    end

    assign rdata = mem[raddr_q];

endmodule

// File: rtl/dsp_frame_engine.sv
// Frame engine: buffers signed samples, then reduces the frame to
// SUM, MAX/MIN or ENERGY and presents the result with a done pulse.
module dsp_frame_engine
    import dsp_pkg::*;
#(
    parameter int W     = 16,
    parameter int DEPTH = 64,
    parameter int ACCW  = 2*W + $clog2(DEPTH)
) (
    input  logic         c,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    input  logic         regE,
    input  logic         ext,
    input  logic [1:0]   mode,
    output logic [W-1:0] dout,
    output logic [W-1:0] dout1,
    output logic         busy,
    output logic         done,
    output logic         full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULLC = CW'(DEPTH);

    localparam logic signed [ACCW-1:0] SMAX =
        {{(ACCW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [ACCW-1:0] SMIN =
        {{(ACCW-W+1){1'b1}}, {(W-1){1'b0}}};
    localparam logic signed [ACCW-1:0] UMAX =
        {{(ACCW-W){1'b0}}, {W{1'b1}}};

    state_t                  state;
    logic [CW-1:0]           count;
    logic [CW-1:0]           nlen;
    logic [AW-1:0]           idx;
    logic [1:0]              mode_q;
    logic signed [ACCW-1:0]  acc;
    logic signed [W-1:0]     maxv;
    logic signed [W-1:0]     minv;

    logic                    wr_ok;
    logic                    start;
    logic                    last;
    logic [CW-1:0]           wcnt;
    logic [AW-1:0]           rd_addr;
    logic [W-1:0]            rdata;
    logic signed [W-1:0]     sample;
    logic signed [2*W-1:0]   sq;
    logic signed [ACCW-1:0]  addend;
    logic [W-1:0]            res0;
    logic [W-1:0]            res1;

    assign wr_ok = (state == ST_IDLE) && regE && (count != FULLC);
    assign wcnt  = count + CW'(wr_ok);
    assign start = (state == ST_IDLE) && ext && (wcnt != '0);
    assign last  = (CW'(idx) == nlen - CW'(1));
    assign busy  = (state == ST_RUN);
    assign full  = (count == FULLC);

    // Address runs one ahead so the registered read lands on idx.
    assign rd_addr = (state == ST_RUN) ? idx + AW'(1) : '0;

    dsp_sample_buf #(.W(W), .DEPTH(DEPTH), .AW(AW)) u_buf (
        .c     (c),
        .rst_n (rst_n),
        .we    (wr_ok),
        .waddr (count[AW-1:0]),
        .wdata (din),
        .raddr (rd_addr),
        .rdata (rdata)
    );

    assign sample = rdata;
    assign sq     = (2*W)'(sample) * (2*W)'(sample);

    always_comb begin
        addend = ACCW'(sample);
        if (mode_q == MODE_ENERGY) begin
            addend = ACCW'(sq);
        end
    end

    always_comb begin
        res0 = '0;
        res1 = '0;
        unique case (mode_q)
            MODE_MAXMIN: begin
                res0 = maxv;
                res1 = minv;
            end
            MODE_ENERGY: begin
                if (acc > UMAX) begin
                    res0 = '1;
                    res1 = W'(1);
                end else begin
                    res0 = acc[W-1:0];
                end
            end
            default: begin
                if (acc > SMAX) begin
                    res0 = SMAX[W-1:0];
                end else if (acc < SMIN) begin
                    res0 = SMIN[W-1:0];
                end else begin
                    res0 = acc[W-1:0];
                end
                res1 = W'(nlen);
            end
        endcase
    end

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            count  <= '0;
            nlen   <= '0;
            idx    <= '0;
            mode_q <= MODE_SUM;
            acc    <= '0;
            maxv   <= '0;
            minv   <= '0;
            dout   <= '0;
            dout1  <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    count <= wcnt;
                    if (start) begin
                        mode_q <= mode;
                        nlen   <= wcnt;
                        idx    <= '0;
                        acc    <= '0;
                        state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc <= acc + addend;
                    idx <= idx + AW'(1);
                    if (idx == '0 || sample > maxv) begin
                        maxv <= sample;
                    end
                    if (idx == '0 || sample < minv) begin
                        minv <= sample;
                    end
                    if (last) begin
                        count <= '0;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    dout  <= res0;
                    dout1 <= res1;
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dsp_frame_engine.sv
// Directed bench for dsp_frame_engine with a frame-level reference model
// checked every cycle, plus literal expectations per scenario.
module tb_dsp_frame_engine;

    localparam int W     = 16;
    localparam int DEPTH = 64;

    logic         c     = 1'b0;
    logic         rst_n = 1'b0;
    logic         regE  = 1'b0;
    logic         ext   = 1'b0;
    logic [1:0]   mode  = 2'b00;
    logic [W-1:0] din   = '0;
    logic [W-1:0] dout;
    logic [W-1:0] dout1;
    logic         busy;
    logic         done;
    logic         full;

    int n_pass = 0;
    int n_tot  = 0;
    bit cmp_on = 1'b0;

    dsp_frame_engine #(.W(W), .DEPTH(DEPTH)) dut (
        .c     (c),
        .rst_n (rst_n),
        .din   (din),
        .regE  (regE),
        .ext   (ext),
        .mode  (mode),
        .dout  (dout),
        .dout1 (dout1),
        .busy  (busy),
        .done  (done),
        .full  (full)
    );

    always #5 c = ~c;

    task automatic chk(input string nm, input longint act,
                       input longint exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Reference model: frame contents as a queue, results by plain math.
    int           qs[$];
    int           ph     = 0;
    int           left   = 0;
    logic [W-1:0] m_dout  = '0;
    logic [W-1:0] m_dout1 = '0;
    logic [W-1:0] p0 = '0;
    logic [W-1:0] p1 = '0;
    logic         m_done = 1'b0;

    function automatic void calc(input logic [1:0] md,
                                 output logic [W-1:0] o0,
                                 output logic [W-1:0] o1);
        longint s;
        int     mx;
        int     mn;
        s  = 0;
        mx = qs[0];
        mn = qs[0];
        foreach (qs[i]) begin
            if (md == 2'b10) s += longint'(qs[i]) * longint'(qs[i]);
            else s += qs[i];
            if (qs[i] > mx) mx = qs[i];
            if (qs[i] < mn) mn = qs[i];
        end
        if (md == 2'b01) begin
            o0 = mx[W-1:0];
            o1 = mn[W-1:0];
        end else if (md == 2'b10) begin
            o0 = (s > 65535) ? 16'hFFFF : s[W-1:0];
            o1 = (s > 65535) ? 16'd1 : 16'd0;
        end else begin
            if (s > 32767) o0 = 16'h7FFF;
            else if (s < -32768) o0 = 16'h8000;
            else o0 = s[W-1:0];
            o1 = W'(qs.size());
        end
    endfunction

    always @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            qs.delete();
            ph      = 0;
            left    = 0;
            m_dout  = '0;
            m_dout1 = '0;
            m_done  = 1'b0;
        end else begin
            m_done = 1'b0;
            if (ph == 1) begin
                left--;
                if (left == 0) begin
                    ph = 2;
                    qs.delete();
                end
            end else if (ph == 2) begin
                m_done  = 1'b1;
                m_dout  = p0;
                m_dout1 = p1;
                ph      = 0;
            end else begin
                if (regE && qs.size() < DEPTH)
                    qs.push_back(int'($signed(din)));
                if (ext && qs.size() > 0) begin
                    calc(mode, p0, p1);
                    left = qs.size();
                    ph   = 1;
                end
            end
        end
    end

    always @(negedge c) begin
        if (cmp_on) begin
            chk("busy", busy, ph == 1);
            chk("done", done, m_done);
            chk("full", full, qs.size() == DEPTH);
            chk("dout", dout, m_dout);
            chk("dout1", dout1, m_dout1);
        end
    end

    task automatic wr(input logic [W-1:0] v);
        @(negedge c);
        regE = 1'b1;
        ext  = 1'b0;
        din  = v;
    endtask

    task automatic run_frame(input logic [1:0] md, input bit r,
                             input logic [W-1:0] v, input int maxc,
                             input bit want, output int lat,
                             output int nbusy);
        bit got;
        @(negedge c);
        ext  = 1'b1;
        mode = md;
        regE = r;
        din  = v;
        got   = 1'b0;
        lat   = -1;
        nbusy = 0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge c);
            ext  = 1'b0;
            regE = 1'b0;
            if (busy) nbusy++;
            if (done) begin
                got = 1'b1;
                lat = i;
                break;
            end
        end
        chk(want ? "done_seen" : "no_done", got, want);
    endtask

    int lat;
    int nb;
    int nd;

    initial begin
        repeat (3) @(negedge c);
        rst_n = 1'b1;
        chk("rst_dout", dout, 0);
        chk("rst_dout1", dout1, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_full", full, 0);
        cmp_on = 1'b1;

        for (int i = 0; i < 64; i++) wr(W'(i));
        @(negedge c);
        regE = 1'b0;
        chk("t1_full", full, 1);
        run_frame(2'b00, 1'b0, '0, 100, 1'b1, lat, nb);
        chk("t1_lat", lat, 65);
        chk("t1_busy", nb, 64);
        chk("t1_sum", dout, 2016);
        chk("t1_n", dout1, 64);

        wr(16'hFFFB);
        wr(16'd7);
        wr(16'd3);
        run_frame(2'b01, 1'b0, '0, 20, 1'b1, lat, nb);
        chk("t2_max", dout, 16'h0007);
        chk("t2_min", dout1, 16'hFFFB);
        chk("t2_busy", nb, 3);
        chk("t2_lat", lat, 4);

        for (int i = 0; i < 64; i++) wr(16'h7FFF);
        run_frame(2'b10, 1'b0, '0, 100, 1'b1, lat, nb);
        chk("t3_energy", dout, 16'hFFFF);
        chk("t3_sat", dout1, 1);

        for (int i = 0; i < 64; i++) wr(16'd1);
        @(negedge c);
        regE = 1'b0;
        chk("t4_full64", full, 1);
        wr(16'd1);
        run_frame(2'b00, 1'b0, '0, 100, 1'b1, lat, nb);
        chk("t4_sum", dout, 64);
        chk("t4_n", dout1, 64);

        wr(16'd3);
        wr(16'hFFFC);
        run_frame(2'b10, 1'b0, '0, 20, 1'b1, lat, nb);
        chk("t5_energy", dout, 25);
        chk("t5_sat", dout1, 0);

        for (int i = 0; i < 3; i++) wr(16'h7FFF);
        run_frame(2'b11, 1'b0, '0, 20, 1'b1, lat, nb);
        chk("t6_satpos", dout, 16'h7FFF);
        chk("t6_n", dout1, 3);

        for (int i = 0; i < 3; i++) wr(16'h8000);
        run_frame(2'b00, 1'b0, '0, 20, 1'b1, lat, nb);
        chk("t7_satneg", dout, 16'h8000);

        wr(16'd10);
        run_frame(2'b00, 1'b1, 16'd20, 20, 1'b1, lat, nb);
        chk("t8_sum", dout, 30);
        chk("t8_n", dout1, 2);

        run_frame(2'b00, 1'b0, '0, 8, 1'b0, lat, nb);
        chk("t9_busy", nb, 0);
        chk("t9_hold", dout, 30);

        wr(16'd4);
        wr(16'd5);
        wr(16'd6);
        @(negedge c);
        regE = 1'b0;
        ext  = 1'b1;
        mode = 2'b00;
        @(posedge c);
        #1 ext = 1'b0;
        @(posedge c);
        #1 chk("t10_busy_run", busy, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("t10_dout", dout, 0);
        chk("t10_dout1", dout1, 0);
        chk("t10_busy", busy, 0);
        chk("t10_done", done, 0);
        chk("t10_full", full, 0);
        @(negedge c);
        rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge c);
            if (done) nd++;
        end
        chk("t10_nodone", nd, 0);

        wr(16'd2);
        run_frame(2'b00, 1'b0, '0, 20, 1'b1, lat, nb);
        chk("t11_sum", dout, 2);
        chk("t11_n", dout1, 1);

        repeat (3) @(negedge c);
        cmp_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
